fpmul_round_stage: RTL and testbench

FPMUL_ROUND_STAGE -- requirements
Module: fpmul_round_stage

---
 rtl/fpmul_pkg.sv | 24 ++
 rtl/fpmul_round_core.sv | 69 ++++++
 rtl/fpmul_round_stage.sv | 109 ++++++++++
 tb/tb_fpmul_round_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_pkg.sv
// Shared widths, IEEE-754 single-precision constants, flag bit positions and
// buffer-occupancy states for the FP multiplier rounding stage.
package fpmul_pkg;

    localparam int DEF_D_WIDTH = 32;
    localparam int DEF_M_WIDTH = 23;
    localparam int DEF_E_WIDTH = 8;
    localparam int DEF_M       = 48;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam int FLAG_W   = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/fpmul_round_core.sv
// Normalize, round and exception handling for a raw significand product.
// Define FPMUL_ROUND_RNE_EN for round-to-nearest-even; otherwise truncate.
module fpmul_round_core
    import fpmul_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int M_WIDTH = DEF_M_WIDTH,
    parameter int E_WIDTH = DEF_E_WIDTH,
    parameter int M       = DEF_M
) (
    input  logic               sign,
    input  logic [E_WIDTH:0]   exp_sum,
    input  logic [M-1:0]       product,
    input  logic               zero,
    output logic [D_WIDTH-1:0] result,
    output logic [FLAG_W-1:0]  flags
);

    localparam int EW = E_WIDTH + 2;

    logic               shift, guard, sticky, round_up, carry, ovf, unf;
    logic [M_WIDTH-1:0] mant_raw, mant;
    logic [M_WIDTH:0]   mant_sum;
    logic [EW-1:0]      exp_w;

    // A product in [2,4) has its leading one one place higher; drop it one bit later.
    assign shift    = product[M-1];
    assign mant_raw = shift ? product[M-2 -: M_WIDTH] : product[M-3 -: M_WIDTH];
    assign guard    = shift ? product[M-2-M_WIDTH] : product[M-3-M_WIDTH];
    assign sticky   = shift ? |product[M-3-M_WIDTH:0] : |product[M-4-M_WIDTH:0];

`ifdef FPMUL_ROUND_RNE_EN
    assign round_up = guard & (sticky | mant_raw[0]);
`else
    assign round_up = 1'b0;
`endif

    assign mant_sum = {1'b0, mant_raw} + {{M_WIDTH{1'b0}}, round_up};
    assign carry    = mant_sum[M_WIDTH];
    assign mant     = mant_sum[M_WIDTH-1:0];

    // Two extra bits keep the biased exponent signed across the full 0..510 input range.
    assign exp_w = {1'b0, exp_sum} - EW'(BIAS)
                 + {{(EW-1){1'b0}}, shift} + {{(EW-1){1'b0}}, carry};
    assign ovf   = !exp_w[EW-1] && (exp_w >= EW'(EXP_MAX));
    assign unf   = exp_w[EW-1] || (exp_w == '0);

    // NOTE: every output gets a default before the priority chain so no latch is inferred.
    always_comb begin
        result          = {sign, exp_w[E_WIDTH-1:0], mant};
        flags           = '0;
        flags[FLAG_INX] = guard | sticky;
        if (zero) begin
            result = {sign, {(D_WIDTH-1){1'b0}}};
            flags  = '0;
        end else if (ovf) begin
            result          = {sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
            flags           = '0;
            flags[FLAG_OVF] = 1'b1;
            flags[FLAG_INX] = 1'b1;
        end else if (unf) begin
            result          = {sign, {(D_WIDTH-1){1'b0}}};
            flags           = '0;
            flags[FLAG_UNF] = 1'b1;
            flags[FLAG_INX] = 1'b1;
        end
    end

endmodule

// File: rtl/fpmul_round_stage.sv
// One-cycle rounding pipeline stage with a skid buffer on a valid/ready link.
// Rounding mode is selected in fpmul_round_core via FPMUL_ROUND_RNE_EN.
module fpmul_round_stage
    import fpmul_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int M_WIDTH = DEF_M_WIDTH,
    parameter int E_WIDTH = DEF_E_WIDTH,
    parameter int M       = DEF_M
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [E_WIDTH:0]   in_exp_sum,
    input  logic [M-1:0]       in_product,
    input  logic               in_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_result,
    output logic [FLAG_W-1:0]  out_flags
);

    state_t               state_q, state_d;
    logic                 in_ready_q, in_fire, out_fire;
    logic [D_WIDTH-1:0]   core_res, main_res_q, main_res_d, skid_res_q, skid_res_d;
    logic [FLAG_W-1:0]    core_flags, main_flags_q, main_flags_d, skid_flags_q, skid_flags_d;

    fpmul_round_core #(
        .D_WIDTH (D_WIDTH),
        .M_WIDTH (M_WIDTH),
        .E_WIDTH (E_WIDTH),
        .M       (M)
    ) u_core (
        .sign    (in_sign),
        .exp_sum (in_exp_sum),
        .product (in_product),
        .zero    (in_zero),
        .result  (core_res),
        .flags   (core_flags)
    );

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_result = main_res_q;
    assign out_flags  = main_flags_q;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_res_d   = main_res_q;
        main_flags_d = main_flags_q;
        skid_res_d   = skid_res_q;
        skid_flags_d = skid_flags_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_res_d   = core_res;
                    main_flags_d = core_flags;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_res_d   = core_res;
                    main_flags_d = core_flags;
                end else if (in_fire) begin
                    skid_res_d   = core_res;
                    skid_flags_d = core_flags;
                    state_d      = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_res_d   = skid_res_q;
                    main_flags_d = skid_flags_q;
                    state_d      = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b0;
            main_res_q   <= '0;
            main_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= (state_d != ST_FULL);
            main_res_q   <= main_res_d;
            main_flags_q <= main_flags_d;
        end
    end

    // NOTE: the skid data needs no reset; it is only read after being written in ST_ONE.
    always_ff @(posedge clk) begin
        skid_res_q   <= skid_res_d;
        skid_flags_q <= skid_flags_d;
    end

endmodule

// File: tb/tb_fpmul_round_stage.sv
// Self-checking bench for fpmul_round_stage: directed corner cases, handshake
// and reset scenarios, then randomized traffic against an arithmetic model.
module tb_fpmul_round_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign, in_zero;
    logic [8:0]  in_exp_sum;
    logic [47:0] in_product;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          n_out  = 0;
    logic        last_in_fire;
    logic        prev_stall = 1'b0;
    logic [34:0] prev_out;
    logic [34:0] sb[$];

    always #5 clk = ~clk;

    fpmul_round_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp_sum (in_exp_sum),
        .in_product (in_product),
        .in_zero    (in_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: value arithmetic on the product, result as {result, ovf, unf, inx}.
    function automatic logic [34:0] model(input logic s, input logic [8:0] es,
                                          input logic [47:0] p, input logic z);
        logic [63:0] prod;
        int sh, mant, g, st, e;
        prod = 64'(p);
        if (z) return {s, 31'd0, 3'b000};
        sh   = (prod >= 64'h8000_0000_0000) ? 1 : 0;
        mant = int'((prod >> (23 + sh)) % 64'h80_0000);
        g    = int'((prod >> (22 + sh)) % 64'd2);
        st   = ((prod % (64'd1 << (22 + sh))) != 64'd0) ? 1 : 0;
        e    = int'(es) - 127 + sh;
`ifdef FPMUL_ROUND_RNE_EN
        if (g == 1 && (st == 1 || mant % 2 == 1)) mant = mant + 1;
`endif
        if (mant == 32'h80_0000) begin
            mant = 0;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 3'b101};
        if (e <= 0)   return {s, 31'd0, 3'b011};
        return {s, e[7:0], mant[22:0], 2'b00, (g == 1 || st == 1)};
    endfunction

    task automatic rand_in();
        logic [63:0] a, b;
        a          = 64'h80_0000 + 64'($urandom_range(0, 32'h7F_FFFF));
        b          = 64'h80_0000 + 64'($urandom_range(0, 32'h7F_FFFF));
        in_product = 48'(a * b);
        in_sign    = 1'($urandom);
        in_exp_sum = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 510))
                                                 : 9'($urandom_range(100, 400));
        in_zero    = ($urandom_range(0, 15) == 0);
    endtask

    // One clock: check handshake against occupancy, score any output, record any input.
    task automatic cycle();
        @(negedge clk);
        check("out_valid_occ", 64'(out_valid), 64'(sb.size() != 0));
        check("in_ready_occ", 64'(in_ready), 64'(sb.size() < 2));
        if (prev_stall) check("hold_stable", 64'({out_result, out_flags}), 64'(prev_out));
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) check("spurious_out", 64'(out_result), 64'hDEAD);
            else check("result", 64'({out_result, out_flags}), 64'(sb.pop_front()));
        end
        last_in_fire = in_valid && in_ready;
        if (last_in_fire) sb.push_back(model(in_sign, in_exp_sum, in_product, in_zero));
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_result, out_flags};
        @(posedge clk);
        #1;
    endtask

    // Single product through an empty stage with out_ready high; result must appear one edge later.
    task automatic send_check(input string tag, input logic s, input logic [8:0] es,
                              input logic [47:0] p, input logic z,
                              input logic [31:0] er, input logic [2:0] ef);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        in_sign = s; in_exp_sum = es; in_product = p; in_zero = z; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_result"}, 64'(out_result), 64'(er));
        check({tag, "_flags"}, 64'(out_flags), 64'(ef));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = 1'b0; in_exp_sum = '0; in_product = '0; in_zero = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_flags", 64'(out_flags), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed corner cases
        send_check("mul_2p25", 1'b0, 9'd254, 48'h9000_0000_0000, 1'b0, 32'h4010_0000, 3'b000);
`ifdef FPMUL_ROUND_RNE_EN
        send_check("round_up", 1'b0, 9'd254, 48'h4000_00C0_0000, 1'b0, 32'h3F80_0002, 3'b001);
        send_check("round_carry", 1'b0, 9'd254, 48'h7FFF_FFC0_0000, 1'b0, 32'h4000_0000, 3'b001);
`else
        send_check("round_up", 1'b0, 9'd254, 48'h4000_00C0_0000, 1'b0, 32'h3F80_0001, 3'b001);
        send_check("round_carry", 1'b0, 9'd254, 48'h7FFF_FFC0_0000, 1'b0, 32'h3FFF_FFFF, 3'b001);
`endif
        send_check("tie_even", 1'b0, 9'd254, 48'h4000_0040_0000, 1'b0, 32'h3F80_0000, 3'b001);
        send_check("overflow", 1'b1, 9'd508, 48'h4000_0000_0000, 1'b0, 32'hFF80_0000, 3'b101);
        send_check("underflow", 1'b0, 9'd100, 48'h4000_0000_0000, 1'b0, 32'h0000_0000, 3'b011);
        send_check("zero_op", 1'b1, 9'd508, 48'h9234_5678_9ABC, 1'b1, 32'h8000_0000, 3'b000);
        send_check("exp_min", 1'b0, 9'd128, 48'h4000_0000_0000, 1'b0, 32'h0080_0000, 3'b000);
        send_check("exp_zero", 1'b0, 9'd127, 48'h4000_0000_0000, 1'b0, 32'h0000_0000, 3'b011);
        send_check("exp_max", 1'b0, 9'd381, 48'h4000_0000_0000, 1'b0, 32'h7F00_0000, 3'b000);

        // Three back-to-back products against a stalled consumer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_in();
        cycle();
        rand_in();
        cycle();
        check("b2b_full_in_ready", 64'(in_ready), 64'd0);
        rand_in();
        cycle();
        cycle();
        out_ready = 1'b1;
        n_out = 0;
        t = 0;
        do begin
            cycle();
            t++;
        end while (!last_in_fire && t < 10);
        in_valid = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 10) begin
            cycle();
            t++;
        end
        check("b2b_out_count", 64'(n_out), 64'd3);

        // Reset while full discards everything
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_in();
        cycle();
        rand_in();
        cycle();
        check("pre_rst_full", 64'(in_ready), 64'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd0);
        check("async_rst_result", 64'(out_result), 64'd0);
        in_valid = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic with random backpressure
        last_in_fire = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!in_valid || last_in_fire) begin
                in_valid = ($urandom_range(0, 9) < 7);
                rand_in();
            end
            out_ready = ($urandom_range(0, 9) < 6);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (sb.size() != 0 && t < 10) begin
            cycle();
            t++;
        end
        check("final_drain", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
